// File: rtl/pad_shifter_if.sv
// pad_shifter_if: CPU-side bus bundle for the controller port block.
// Carries the $4016 write, per-port read strobes, pad state and serial data.
interface pad_shifter_if #(
    parameter int NUM_PORTS = 2,
    parameter int BUTTONS   = 8,
    parameter int MULTITAP  = 0
);
    localparam int NUM_PADS = NUM_PORTS * (MULTITAP + 1);

    logic                          cpu_en;
    logic [NUM_PADS*BUTTONS-1:0]   buttons;
    logic                          strobe_wr;
    logic                          strobe_data;
    logic [NUM_PORTS-1:0]          read;
    logic [NUM_PORTS-1:0]          port_data;
    logic [NUM_PORTS-1:0]          done;

    modport master (
        output cpu_en,
        output buttons,
        output strobe_wr,
        output strobe_data,
        output read,
        input  port_data,
        input  done
    );

    modport slave (
        input  cpu_en,
        input  buttons,
        input  strobe_wr,
        input  strobe_data,
        input  read,
        output port_data,
        output done
    );
endinterface

// File: rtl/pad_shifter.sv
// pad_shifter: strobe/latch/shift controller ports for up to 4 ports,
// with optional two-pad-plus-signature chaining per port.
module pad_shifter #(
    parameter int NUM_PORTS = 2,
    parameter int BUTTONS   = 8,
    parameter int MULTITAP  = 0
) (
    input  logic             clk,
    input  logic             reset,
    pad_shifter_if.slave     io_bus
);
    localparam int LEN = (MULTITAP != 0) ? (2 * BUTTONS + 8) : BUTTONS;
    localparam int CW  = $clog2(LEN + 1);
    localparam logic [CW-1:0]  LEN_C  = CW'(LEN);
    localparam logic [LEN-1:0] FILL_C = LEN'(1) << (LEN - 1);

    logic                 r_strobe_q;
    logic [LEN-1:0]       r_sh  [NUM_PORTS];
    logic [CW-1:0]        r_cnt [NUM_PORTS];
    logic [LEN-1:0]       w_img [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_port_data;
    logic [NUM_PORTS-1:0] w_done;

    // Load image per port: the pad alone, or signature/second pad/first pad.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_img
        if (MULTITAP != 0) begin : g_mt
            localparam logic [7:0] SIG = 8'h08 >> p;
            assign w_img[p] = {
                SIG,
                io_bus.buttons[(p+NUM_PORTS)*BUTTONS +: BUTTONS],
                io_bus.buttons[p*BUTTONS +: BUTTONS]
            };
        end else begin : g_single
            assign w_img[p] = io_bus.buttons[p*BUTTONS +: BUTTONS];
        end
    end

    // Strobe latch, shift registers and saturating counters; all gated by cpu_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_strobe_q <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_sh[p]  <= '1;
                r_cnt[p] <= LEN_C;
            end
        end else if (io_bus.cpu_en) begin
            if (io_bus.strobe_wr) begin
                r_strobe_q <= io_bus.strobe_data;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    r_sh[p]  <= w_img[p];
                    r_cnt[p] <= '0;
                end
            end else if (r_strobe_q) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    r_sh[p]  <= w_img[p];
                    r_cnt[p] <= '0;
                end
            end else begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (io_bus.read[p]) begin
                        r_sh[p] <= (r_sh[p] >> 1) | FILL_C;
                        if (r_cnt[p] != LEN_C) begin
                            r_cnt[p] <= r_cnt[p] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Serial bit is the register LSB, so data is valid in the read cycle itself.
    always_comb begin
        w_port_data = '0;
        w_done      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_port_data[p] = r_sh[p][0];
            w_done[p]      = (r_cnt[p] == LEN_C);
        end
    end

    assign io_bus.port_data = w_port_data;
    assign io_bus.done      = w_done;
endmodule
